// File: rtl/grad_dac_serialiser.sv
// SPI serialiser for up to four gradient DACs: one shared SCLK, per-channel CSn/MOSI,
// and readback capture on MISO. It accepts one word per frame from the gradient sequencer.
module grad_dac_serialiser #(
    parameter int FRAME_BITS = 32,
    parameter int GAP_CYCLES = 4
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [31:0] data_i,
    input  logic [3:0]  valid_i,
    input  logic [5:0]  spi_clk_div_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic [3:0]  csn_o,
    output logic [3:0]  mosi_o,
    output logic        busy_o,
    output logic        data_lost_o,
    output logic [15:0] adc_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEAD     = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_TRAIL    = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    localparam int         LP_ALIGN    = 32 - FRAME_BITS;
    localparam logic [5:0] LP_LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [3:0] LP_GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [30:0] r_shreg;
    logic [3:0]  r_mask;
    logic [5:0]  r_div;
    logic [5:0]  r_cnt;
    logic [5:0]  r_bitcnt;
    logic [3:0]  r_gap;
    logic [15:0] r_rx;
    logic        r_sclk;
    logic [3:0]  r_csn;
    logic [3:0]  r_mosi;
    logic        r_busy;
    logic        r_data_lost;
    logic [15:0] r_adc;

    logic [31:0] w_aligned;
    logic        w_req;
    logic        w_phase_end;

    // Left-justify the frame so its first bit always sits at bit 31.
    assign w_aligned   = data_i << LP_ALIGN;
    assign w_req       = |valid_i;
    assign w_phase_end = (r_cnt == 6'd0);

    // Frame sequencer with all SPI pins and status held in registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state     <= ST_IDLE;
            r_shreg     <= 31'd0;
            r_mask      <= 4'd0;
            r_div       <= 6'd0;
            r_cnt       <= 6'd0;
            r_bitcnt    <= 6'd0;
            r_gap       <= 4'd0;
            r_rx        <= 16'd0;
            r_sclk      <= 1'b0;
            r_csn       <= 4'hF;
            r_mosi      <= 4'd0;
            r_busy      <= 1'b0;
            r_data_lost <= 1'b0;
            r_adc       <= 16'd0;
        end else begin
            r_data_lost <= r_busy && w_req;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_shreg  <= w_aligned[30:0];
                        r_mask   <= valid_i;
                        r_div    <= spi_clk_div_i;
                        r_cnt    <= spi_clk_div_i;
                        r_bitcnt <= 6'd0;
                        r_rx     <= 16'd0;
                        r_csn    <= ~valid_i;
                        r_mosi   <= valid_i & {4{w_aligned[31]}};
                        r_sclk   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LEAD;
                    end
                end
                ST_LEAD, ST_SHIFT_LO: begin
                    // Rising SCLK edge: the DAC drove MISO on the previous falling edge.
                    if (w_phase_end) begin
                        r_sclk  <= 1'b1;
                        r_cnt   <= r_div;
                        r_rx    <= {r_rx[14:0], miso_i};
                        r_state <= ST_SHIFT_HI;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_sclk   <= 1'b0;
                        r_cnt    <= r_div;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_bitcnt == LP_LAST_BIT) begin
                            r_state <= ST_TRAIL;
                        end else begin
                            r_shreg <= {r_shreg[29:0], 1'b0};
                            r_mosi  <= r_mask & {4{r_shreg[30]}};
                            r_state <= ST_SHIFT_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ST_TRAIL: begin
                    if (w_phase_end) begin
                        r_csn   <= 4'hF;
                        r_mosi  <= 4'd0;
                        r_adc   <= r_rx;
                        r_gap   <= LP_GAP_LOAD;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == 4'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: begin
                    r_sclk  <= 1'b0;
                    r_csn   <= 4'hF;
                    r_mosi  <= 4'd0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk_o      = r_sclk;
    assign csn_o       = r_csn;
    assign mosi_o      = r_mosi;
    assign busy_o      = r_busy;
    assign data_lost_o = r_data_lost;
    assign adc_o       = r_adc;

endmodule

// File: tb/tb_grad_dac_serialiser.sv
// Scoreboard bench for grad_dac_serialiser: stimulus pushes per-frame expectations,
// a negedge monitor rebuilds each frame from the pins and compares when busy_o drops.
module tb_grad_dac_serialiser;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic [3:0]  valid;
    logic [3:0]  valid24;
    logic [5:0]  div;
    logic        miso;
    logic        miso24;
    logic [31:0] miso_pat;
    logic        sel24;

    logic        sclk, busy, lost;
    logic [3:0]  csn, mosi;
    logic [15:0] adc;
    logic        sclk24, busy24, lost24;
    logic [3:0]  csn24, mosi24;
    logic [15:0] adc24;

    logic        m_sclk, m_busy, m_lost;
    logic [3:0]  m_csn, m_mosi;
    logic [15:0] m_adc;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]       mask;
        logic [3:0][31:0] words;
        logic [3:0]       mosi_or;
        logic [15:0]      rises;
        logic [15:0]      busy_len;
        logic [15:0]      phase;
        logic [15:0]      adc;
        logic [15:0]      adc_pre;
        logic [15:0]      lost;
    } exp_t;

    exp_t sbq[$];

    grad_dac_serialiser dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .data_i(data), .valid_i(valid),
        .spi_clk_div_i(div), .miso_i(miso), .sclk_o(sclk), .csn_o(csn), .mosi_o(mosi),
        .busy_o(busy), .data_lost_o(lost), .adc_o(adc)
    );

    grad_dac_serialiser #(.FRAME_BITS(24), .GAP_CYCLES(4)) dut24 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .data_i(data), .valid_i(valid24),
        .spi_clk_div_i(div), .miso_i(miso24), .sclk_o(sclk24), .csn_o(csn24), .mosi_o(mosi24),
        .busy_o(busy24), .data_lost_o(lost24), .adc_o(adc24)
    );

    assign m_sclk = sel24 ? sclk24 : sclk;
    assign m_busy = sel24 ? busy24 : busy;
    assign m_lost = sel24 ? lost24 : lost;
    assign m_csn  = sel24 ? csn24  : csn;
    assign m_mosi = sel24 ? mosi24 : mosi;
    assign m_adc  = sel24 ? adc24  : adc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [3:0] m, input logic [31:0] w, input int rises,
                                    input int blen, input int ph, input logic [15:0] a,
                                    input logic [15:0] pre, input int nlost);
        exp_t e;
        e.mask = m;
        for (int n = 0; n < 4; n++) e.words[n] = m[n] ? w : 32'd0;
        e.mosi_or  = (w != 32'd0) ? m : 4'd0;
        e.rises    = 16'(rises);
        e.busy_len = 16'(blen);
        e.phase    = 16'(ph);
        e.adc      = a;
        e.adc_pre  = pre;
        e.lost     = 16'(nlost);
        return e;
    endfunction

    // MISO model: DAC presents the next pattern bit after every falling SCLK edge.
    initial begin
        int  fcnt;
        logic psclk;
        fcnt  = 0;
        psclk = 1'b0;
        forever begin
            @(negedge clk);
            if (csn == 4'hF) fcnt = 0;
            else if (psclk && !sclk) fcnt++;
            psclk = sclk;
            miso = (fcnt < 32) ? miso_pat[31 - fcnt] : 1'b0;
        end
    end

    // Monitor: reconstruct each frame from the pins, then pop and compare at busy fall.
    initial begin
        logic             pbusy, psclk, in_frame, had_fall, csn_bad;
        logic [3:0][31:0] words;
        logic [3:0]       mosi_or, csn_seen;
        logic [15:0]      adc_pre;
        int               rises, blen, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max, nlost;
        exp_t             e;
        pbusy = 1'b0; psclk = 1'b0; in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0; pbusy = 1'b0; psclk = 1'b0;
            end else begin
                if (m_busy && !pbusy) begin
                    in_frame = 1'b1; had_fall = 1'b0; csn_bad = 1'b0;
                    words = '0; mosi_or = 4'd0; csn_seen = 4'd0; adc_pre = 16'd0;
                    rises = 0; blen = 0; hi_run = 0; lo_run = 0; nlost = 0;
                    hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
                end
                if (in_frame && m_busy) begin
                    blen++;
                    if (m_lost) nlost++;
                    mosi_or |= m_mosi;
                    if (m_csn != 4'hF) begin
                        if (csn_seen != 4'd0 && ~m_csn != csn_seen) csn_bad = 1'b1;
                        csn_seen |= ~m_csn;
                        adc_pre = m_adc;
                    end
                    if (m_sclk) begin
                        if (!psclk) begin
                            rises++;
                            for (int n = 0; n < 4; n++) words[n] = {words[n][30:0], m_mosi[n]};
                            if (had_fall) begin
                                if (lo_run < lo_min) lo_min = lo_run;
                                if (lo_run > lo_max) lo_max = lo_run;
                            end
                            hi_run = 0;
                        end
                        hi_run++;
                    end else begin
                        if (psclk) begin
                            if (hi_run < hi_min) hi_min = hi_run;
                            if (hi_run > hi_max) hi_max = hi_run;
                            had_fall = 1'b1;
                            lo_run = 0;
                        end
                        lo_run++;
                    end
                end
                if (!m_busy && pbusy && in_frame) begin
                    in_frame = 1'b0;
                    if (sbq.size() == 0) begin
                        chk("unexpected_frame", 32'(sbq.size()), 32'd1);
                    end else begin
                        e = sbq.pop_front();
                        for (int n = 0; n < 4; n++) chk($sformatf("mosi_word%0d", n), words[n], e.words[n]);
                        chk("mosi_or", 32'(mosi_or), 32'(e.mosi_or));
                        chk("csn_active", 32'(csn_seen), 32'(e.mask));
                        chk("csn_stable", 32'(csn_bad), 32'd0);
                        chk("sclk_rises", 32'(rises), 32'(e.rises));
                        chk("busy_len", 32'(blen), 32'(e.busy_len));
                        chk("hi_min", 32'(hi_min), 32'(e.phase));
                        chk("hi_max", 32'(hi_max), 32'(e.phase));
                        chk("lo_min", 32'(lo_min), 32'(e.phase));
                        chk("lo_max", 32'(lo_max), 32'(e.phase));
                        chk("adc_pre", 32'(adc_pre), 32'(e.adc_pre));
                        chk("adc", 32'(m_adc), 32'(e.adc));
                        chk("data_lost", 32'(nlost), 32'(e.lost));
                    end
                end
                pbusy = m_busy;
                psclk = m_sclk;
            end
        end
    end

    task automatic start_frame(input logic [3:0] m, input logic [31:0] d, input logic [5:0] dv,
                               input logic [31:0] pat, input bit use24, input bit push, input exp_t e);
        data = d; div = dv; miso_pat = pat;
        if (use24) valid24 = m;
        else valid = m;
        if (push) sbq.push_back(e);
        @(negedge clk);
        valid = 4'd0; valid24 = 4'd0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_busy) chk("wait_idle_timeout", 32'(m_busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; data = 32'd0; valid = 4'd0; valid24 = 4'd0; div = 6'd0;
        miso_pat = 32'd0; miso24 = 1'b0; sel24 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_csn", 32'(csn), 32'hF);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);
        chk("rst_adc", 32'(adc), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // div=0, all channels: 65 phases of 1 clock plus 4 gap clocks.
        start_frame(4'hF, 32'habcd0123, 6'd0, 32'h12345678, 1'b0, 1'b1,
                    mk_exp(4'hF, 32'habcd0123, 32, 69, 1, 16'h5678, 16'h0000, 0));
        chk("busy_next_cycle", 32'(busy), 32'd1);
        wait_idle(200);

        // Channels 0 and 2 only, 31-clock phases; valid held 3 clocks mid-frame.
        start_frame(4'b0101, 32'h12345678, 6'd30, 32'h0000beef, 1'b0, 1'b1,
                    mk_exp(4'b0101, 32'h12345678, 32, 2019, 31, 16'hbeef, 16'h5678, 3));
        repeat (100) @(negedge clk);
        data = 32'hffffffff; div = 6'd1; valid = 4'hF;
        repeat (3) @(negedge clk);
        valid = 4'd0;
        wait_idle(2500);

        // Single-clock request mid-frame must be dropped, frame keeps its own word.
        start_frame(4'b0010, 32'hcafef00d, 6'd3, 32'hffff0000, 1'b0, 1'b1,
                    mk_exp(4'b0010, 32'hcafef00d, 32, 264, 4, 16'h0000, 16'hbeef, 1));
        repeat (50) @(negedge clk);
        data = 32'hdeadbeef; valid = 4'hF;
        @(negedge clk);
        valid = 4'd0;
        wait_idle(400);

        // Back-to-back: request on the first idle cycle.
        start_frame(4'hF, 32'h00000001, 6'd0, 32'h00008001, 1'b0, 1'b1,
                    mk_exp(4'hF, 32'h00000001, 32, 69, 1, 16'h8001, 16'h0000, 0));
        wait_idle(200);

        // Abandoned frame: reset pulse mid-frame.
        start_frame(4'hF, 32'h0f0f0f0f, 6'd1, 32'h0, 1'b0, 1'b0, '0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_csn", 32'(csn), 32'hF);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mosi", 32'(mosi), 32'd0);
        #9 rst_n = 1'b1;
        @(negedge clk);

        start_frame(4'b1000, 32'h80000001, 6'd1, 32'h0000a5a5, 1'b0, 1'b1,
                    mk_exp(4'b1000, 32'h80000001, 32, 134, 2, 16'ha5a5, 16'h0000, 0));
        wait_idle(300);

        // 24-bit instance: 49 phases of 3 clocks plus 4 gap clocks.
        sel24 = 1'b1;
        start_frame(4'hF, 32'h00a5a5a5, 6'd2, 32'h0, 1'b1, 1'b1,
                    mk_exp(4'hF, 32'h00a5a5a5, 24, 151, 3, 16'h0000, 16'h0000, 0));
        wait_idle(300);
        repeat (5) @(negedge clk);
        sel24 = 1'b0;

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
